johnson_code_checker: RTL and testbench



---
 rtl/johnson_code_checker.sv | 153 +++++++++++++++
 tb/tb_johnson_code_checker.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/johnson_code_checker.sv
// rtl/johnson_code_checker.sv - Johnson code decoder with sequence lock tracking and error counting
module johnson_code_checker #(
  parameter int N        = 4,
  parameter int IW       = 3,
  parameter int LOCK_CNT = 3,
  parameter int EW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  code_in,
  input  logic          code_valid,
  input  logic          clear_err,
  output logic [IW-1:0] index,
  output logic          index_valid,
  output logic          illegal,
  output logic          skip,
  output logic          lock,
  output logic [EW-1:0] err_cnt
);

  localparam int GW = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {UNLOCKED, ACQ, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] good_q, good_d;
  logic [IW-1:0] prev_q, prev_d;
  logic [IW-1:0] index_d;
  logic          iv_d, ill_d, skip_d, lock_d, err_inc;
  logic [EW-1:0] err_d;

  logic          dec_ok;
  logic [IW-1:0] dec_idx;
  logic [N-1:0]  pat;
  logic [IW-1:0] succ;
  logic          is_step, is_hold;

  // Ones packed at the MSB end give the first half of the cycle, ones at the LSB end the second half.
  always_comb begin
    dec_ok  = 1'b0;
    dec_idx = '0;
    pat     = '0;
    for (int k = 0; k <= N; k++) begin
      pat = ~({N{1'b1}} >> k);
      if (code_in == pat) begin
        dec_ok  = 1'b1;
        dec_idx = IW'(k);
      end
    end
    for (int m = 1; m < N; m++) begin
      pat = {N{1'b1}} >> (N - m);
      if (code_in == pat) begin
        dec_ok  = 1'b1;
        dec_idx = IW'(2 * N - m);
      end
    end
  end

  assign succ    = (prev_q == IW'(2 * N - 1)) ? '0 : prev_q + IW'(1);
  assign is_step = (dec_idx == succ);
  assign is_hold = (dec_idx == prev_q);

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    prev_d  = prev_q;
    index_d = index;
    iv_d    = 1'b0;
    ill_d   = 1'b0;
    skip_d  = 1'b0;
    lock_d  = lock;
    err_inc = 1'b0;
    if (code_valid) begin
      if (!dec_ok) begin
        ill_d   = 1'b1;
        err_inc = 1'b1;
        lock_d  = 1'b0;
        state_d = UNLOCKED;
      end else begin
        prev_d  = dec_idx;
        index_d = dec_idx;
        iv_d    = 1'b1;
        case (state_q)
          UNLOCKED: begin
            good_d  = '0;
            state_d = ACQ;
          end
          ACQ: begin
            if (is_step) begin
              if (good_q >= GW'(LOCK_CNT - 1)) begin
                good_d  = GW'(LOCK_CNT);
                lock_d  = 1'b1;
                state_d = LOCKED;
              end else begin
                good_d = good_q + GW'(1);
              end
            end else if (!is_hold) begin
              skip_d = 1'b1;
              good_d = '0;
            end
          end
          LOCKED: begin
            if (!is_step && !is_hold) begin
              skip_d  = 1'b1;
              err_inc = 1'b1;
              lock_d  = 1'b0;
              good_d  = '0;
              state_d = ACQ;
            end
          end
          default: begin
            lock_d  = 1'b0;
            state_d = UNLOCKED;
          end
        endcase
      end
    end
  end

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_comb begin
    err_d = err_cnt;
    if (clear_err)
      err_d = '0;
    else if (err_inc && (err_cnt != {EW{1'b1}}))
      err_d = err_cnt + EW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= UNLOCKED;
      good_q      <= '0;
      prev_q      <= '0;
      index       <= '0;
      index_valid <= 1'b0;
      illegal     <= 1'b0;
      skip        <= 1'b0;
      lock        <= 1'b0;
      err_cnt     <= '0;
    end else begin
      state_q     <= state_d;
      good_q      <= good_d;
      prev_q      <= prev_d;
      index       <= index_d;
      index_valid <= iv_d;
      illegal     <= ill_d;
      skip        <= skip_d;
      lock        <= lock_d;
      err_cnt     <= err_d;
    end
  end

endmodule

// File: tb/tb_johnson_code_checker.sv
// tb/tb_johnson_code_checker.sv - directed scoreboard bench for johnson_code_checker
module tb_johnson_code_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] code_in = '0;
  logic       code_valid = 1'b0;
  logic       clear_err = 1'b0;

  logic [2:0] index, index2;
  logic       index_valid, illegal, skip, lock;
  logic       index_valid2, illegal2, skip2, lock2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] idx;
    logic       iv;
    logic       ill;
    logic       sk;
    logic       lk;
    logic [7:0] e;
    logic [1:0] e2;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  johnson_code_checker #(.N(4), .IW(3), .LOCK_CNT(3), .EW(8)) dut (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid), .clear_err(clear_err),
    .index(index), .index_valid(index_valid), .illegal(illegal), .skip(skip), .lock(lock),
    .err_cnt(err_cnt)
  );

  johnson_code_checker #(.N(4), .IW(3), .LOCK_CNT(3), .EW(2)) dut2 (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid), .clear_err(clear_err),
    .index(index2), .index_valid(index_valid2), .illegal(illegal2), .skip(skip2), .lock(lock2),
    .err_cnt(err_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] c, input logic v, input logic clr,
                      input logic [2:0] idx, input logic iv, input logic ill, input logic sk,
                      input logic lk, input logic [7:0] e, input logic [1:0] e2);
    exp_t x;
    code_in    = c;
    code_valid = v;
    clear_err  = clr;
    sb.push_back('{idx, iv, ill, sk, lk, e, e2});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("index",       32'(index),       32'(x.idx));
    chk("index_valid", 32'(index_valid), 32'(x.iv));
    chk("illegal",     32'(illegal),     32'(x.ill));
    chk("skip",        32'(skip),        32'(x.sk));
    chk("lock",        32'(lock),        32'(x.lk));
    chk("err_cnt",     32'(err_cnt),     32'(x.e));
    chk("err_cnt_ew2", 32'(err_cnt2),    32'(x.e2));
    chk("illegal_ew2", 32'(illegal2),    32'(x.ill));
    code_valid = 1'b0;
    clear_err  = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_index"}, 32'(index), 0);
    chk({tag, "_iv"},    32'(index_valid), 0);
    chk({tag, "_ill"},   32'(illegal), 0);
    chk({tag, "_skip"},  32'(skip), 0);
    chk({tag, "_lock"},  32'(lock), 0);
    chk({tag, "_err"},   32'(err_cnt), 0);
    chk({tag, "_lock2"}, 32'(lock2), 0);
    chk({tag, "_idx2"},  32'(index2), 0);
    chk({tag, "_iv2"},   32'(index_valid2), 0);
    chk({tag, "_skip2"}, 32'(skip2), 0);
  endtask

  initial begin
    #12;
    chk_zero("reset");
    @(posedge clk);
    #1 rst = 1'b1;

    //    code     v  clr idx iv ill sk lk e  e2
    step(4'b0000, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    step(4'b1000, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    step(4'b1100, 1, 0, 2, 1, 0, 0, 0, 0, 0);
    step(4'b1110, 1, 0, 3, 1, 0, 0, 1, 0, 0);
    step(4'b1111, 1, 0, 4, 1, 0, 0, 1, 0, 0);
    step(4'b0111, 1, 0, 5, 1, 0, 0, 1, 0, 0);
    step(4'b0011, 1, 0, 6, 1, 0, 0, 1, 0, 0);
    step(4'b0001, 1, 0, 7, 1, 0, 0, 1, 0, 0);
    step(4'b0000, 1, 0, 0, 1, 0, 0, 1, 0, 0);
    step(4'b1000, 1, 0, 1, 1, 0, 0, 1, 0, 0);
    // illegal while locked, then reacquire
    step(4'b1010, 1, 0, 1, 0, 1, 0, 0, 1, 1);
    step(4'b1100, 1, 0, 2, 1, 0, 0, 0, 1, 1);
    step(4'b1110, 1, 0, 3, 1, 0, 0, 0, 1, 1);
    step(4'b1111, 1, 0, 4, 1, 0, 0, 0, 1, 1);
    step(4'b0111, 1, 0, 5, 1, 0, 0, 1, 1, 1);
    step(4'b0011, 1, 0, 6, 1, 0, 0, 1, 1, 1);
    step(4'b0001, 1, 0, 7, 1, 0, 0, 1, 1, 1);
    step(4'b0000, 1, 0, 0, 1, 0, 0, 1, 1, 1);
    step(4'b1000, 1, 0, 1, 1, 0, 0, 1, 1, 1);
    step(4'b1100, 1, 0, 2, 1, 0, 0, 1, 1, 1);
    // skip while locked
    step(4'b1111, 1, 0, 4, 1, 0, 1, 0, 2, 2);
    step(4'b0111, 1, 0, 5, 1, 0, 0, 0, 2, 2);
    step(4'b0011, 1, 0, 6, 1, 0, 0, 0, 2, 2);
    step(4'b0001, 1, 0, 7, 1, 0, 0, 1, 2, 2);
    step(4'b0000, 1, 0, 0, 1, 0, 0, 1, 2, 2);
    step(4'b1000, 1, 0, 1, 1, 0, 0, 1, 2, 2);
    step(4'b1100, 1, 0, 2, 1, 0, 0, 1, 2, 2);
    step(4'b1110, 1, 0, 3, 1, 0, 0, 1, 2, 2);
    // holds separated by idle cycles
    step(4'b1010, 0, 0, 3, 0, 0, 0, 1, 2, 2);
    step(4'b0000, 0, 0, 3, 0, 0, 0, 1, 2, 2);
    step(4'b1110, 1, 0, 3, 1, 0, 0, 1, 2, 2);
    step(4'b0000, 0, 0, 3, 0, 0, 0, 1, 2, 2);
    step(4'b0000, 0, 0, 3, 0, 0, 0, 1, 2, 2);
    step(4'b1110, 1, 0, 3, 1, 0, 0, 1, 2, 2);
    step(4'b1110, 0, 1, 3, 0, 0, 0, 1, 0, 0);
    // saturation and clear priority
    step(4'b1010, 1, 0, 3, 0, 1, 0, 0, 1, 1);
    step(4'b1011, 1, 0, 3, 0, 1, 0, 0, 2, 2);
    step(4'b0100, 1, 0, 3, 0, 1, 0, 0, 3, 3);
    step(4'b1001, 1, 0, 3, 0, 1, 0, 0, 4, 3);
    step(4'b0110, 1, 0, 3, 0, 1, 0, 0, 5, 3);
    step(4'b0101, 1, 1, 3, 0, 1, 0, 0, 0, 0);
    // relock, then asynchronous reset between edges
    step(4'b0000, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    step(4'b1000, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    step(4'b1100, 1, 0, 2, 1, 0, 0, 0, 0, 0);
    step(4'b1110, 1, 0, 3, 1, 0, 0, 1, 0, 0);
    #3 rst = 1'b0;
    #1;
    chk_zero("async_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
